// File: rtl/rgb_pkg.sv
// Shared definitions for the pulse-width-coded serial receiver.
//   CNT_W_DEF  : default width of the pulse-measure counters and timing inputs
//   rx_state_e : receiver FSM state encoding
package rgb_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2,
        ST_STUCK = 2'd3
    } rx_state_e;

endpackage

// File: rtl/rgb_rx_meter.sv
// Front end of the receiver: synchronises the asynchronous input, detects
// edges and measures how long the synchronised line has held each level.
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset
//   din_i    : raw asynchronous serial input
//   rise_o   : synchronised line rose this cycle
//   fall_o   : synchronised line fell this cycle
//   hi_w_o   : cycles the line was high (valid as the width on the fall cycle)
//   lo_w_o   : cycles the line has been low since the last fall
//   hi_sat_o : high counter is saturated at its maximum
module rgb_rx_meter import rgb_pkg::*; #(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             din_i,
    output logic             rise_o,
    output logic             fall_o,
    output logic [CNT_W-1:0] hi_w_o,
    output logic [CNT_W-1:0] lo_w_o,
    output logic             hi_sat_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             sync1_q;
    logic             sync2_q;
    logic             dly_q;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic [CNT_W-1:0] lo_q, lo_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // The edge cycle itself counts as the first cycle of the new level, so on
    // the following edge the opposite counter holds exactly the pulse width.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (sync2_q) begin
            hi_d = dly_q ? sat_inc(hi_q) : CNT_ONE;
        end else begin
            lo_d = !dly_q ? sat_inc(lo_q) : CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign rise_o   = sync2_q & ~dly_q;
    assign fall_o   = ~sync2_q & dly_q;
    assign hi_w_o   = hi_q;
    assign lo_w_o   = lo_q;
    assign hi_sat_o = (hi_q == CNT_MAX);

endmodule

// File: rtl/rgb_rx.sv
// Single-wire pulse-width-coded serial receiver. High pulses at or above
// hi_thresh decode as 1, shorter ones as 0, pulses under min_hi are ignored.
// A low period of latch_len cycles ends a frame. Bytes arrive MSB first and
// are offered on a valid/ready handshake.
//   clk, reset(active-low async), en, din
//   hi_thresh, min_hi, latch_len : timing thresholds in clk cycles
//   ready                        : downstream accept
//   data, valid                  : received byte and its handshake flag
//   frame_end, err_overrun, err_partial, err_stuck : one-cycle status pulses
//   busy                         : FSM not idle
module rgb_rx import rgb_pkg::*; #(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             din,
    input  logic [CNT_W-1:0] hi_thresh,
    input  logic [CNT_W-1:0] min_hi,
    input  logic [CNT_W-1:0] latch_len,
    input  logic             ready,
    output logic [7:0]       data,
    output logic             valid,
    output logic             frame_end,
    output logic             err_overrun,
    output logic             err_partial,
    output logic             err_stuck,
    output logic             busy
);

    logic             rise, fall, hi_sat;
    logic [CNT_W-1:0] hi_w, lo_w;
    logic [CNT_W-1:0] latch_eff;

    rx_state_e  state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       fe_q, fe_d;
    logic       ovr_q, ovr_d;
    logic       part_q, part_d;
    logic       stuck_q, stuck_d;
    logic       byte_done;
    logic       rx_bit;

    rgb_rx_meter #(
        .CNT_W (CNT_W)
    ) u_meter (
        .clk_i    (clk),
        .rst_ni   (reset),
        .din_i    (din),
        .rise_o   (rise),
        .fall_o   (fall),
        .hi_w_o   (hi_w),
        .lo_w_o   (lo_w),
        .hi_sat_o (hi_sat)
    );

    // A zero latch length would end the frame before any bit could start.
    assign latch_eff = (latch_len == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : latch_len;
    assign rx_bit    = (hi_w >= hi_thresh);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q & ~ready;
        fe_d      = 1'b0;
        ovr_d     = 1'b0;
        part_d    = 1'b0;
        stuck_d   = 1'b0;
        byte_done = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rise) state_d = ST_HIGH;
            end
            ST_HIGH: begin
                if (fall) begin
                    state_d = ST_LOW;
                    if (hi_w >= min_hi) begin
                        shift_d   = {shift_q[6:0], rx_bit};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        byte_done = (bit_cnt_q == 3'd7);
                    end
                end else if (hi_sat) begin
                    state_d   = ST_STUCK;
                    stuck_d   = 1'b1;
                    bit_cnt_d = 3'd0;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    state_d = ST_HIGH;
                end else if (lo_w >= latch_eff) begin
                    state_d   = ST_IDLE;
                    fe_d      = 1'b1;
                    part_d    = (bit_cnt_q != 3'd0);
                    bit_cnt_d = 3'd0;
                end
            end
            ST_STUCK: begin
                if (fall) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Disabling drops any partial byte silently; the handshake keeps going.
        if (!en) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            byte_done = 1'b0;
            fe_d      = 1'b0;
            part_d    = 1'b0;
            stuck_d   = 1'b0;
        end

        // A full byte only overwrites the output when the old one is gone or
        // being consumed this very cycle; otherwise it is dropped.
        if (byte_done) begin
            if (!valid_q || ready) begin
                data_d  = shift_d;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
            ovr_q     <= 1'b0;
            part_q    <= 1'b0;
            stuck_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            fe_q      <= fe_d;
            ovr_q     <= ovr_d;
            part_q    <= part_d;
            stuck_q   <= stuck_d;
        end
    end

    assign data        = data_q;
    assign valid       = valid_q;
    assign frame_end   = fe_q;
    assign err_overrun = ovr_q;
    assign err_partial = part_q;
    assign err_stuck   = stuck_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rgb_rx.sv
// Directed bench for rgb_rx: a table of single bytes with hand-computed
// results, followed by hand-written overrun, partial-frame, glitch, stuck-line,
// enable-drop and mid-byte-reset sequences.
module tb_rgb_rx;

    localparam int LOWW = 50;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        din;
    logic [15:0] hi_thresh;
    logic [15:0] min_hi;
    logic [15:0] latch_len;
    logic        ready;
    logic [7:0]  data;
    logic        valid;
    logic        frame_end;
    logic        err_overrun;
    logic        err_partial;
    logic        err_stuck;
    logic        busy;

    rgb_rx #(.CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .din         (din),
        .hi_thresh   (hi_thresh),
        .min_hi      (min_hi),
        .latch_len   (latch_len),
        .ready       (ready),
        .data        (data),
        .valid       (valid),
        .frame_end   (frame_end),
        .err_overrun (err_overrun),
        .err_partial (err_partial),
        .err_stuck   (err_stuck),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Event counters sampled on the falling edge, away from the active edge.
    int   n_fe = 0, n_part = 0, n_ovr = 0, n_stuck = 0, n_vrise = 0, n_fe_part = 0;
    logic v_prev = 1'b0;

    always @(negedge clk) begin
        if (frame_end)               n_fe      <= n_fe + 1;
        if (err_partial)             n_part    <= n_part + 1;
        if (err_overrun)             n_ovr     <= n_ovr + 1;
        if (err_stuck)               n_stuck   <= n_stuck + 1;
        if (frame_end && err_partial) n_fe_part <= n_fe_part + 1;
        if (valid && !v_prev)        n_vrise   <= n_vrise + 1;
        v_prev <= valid;
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // All stimulus changes on the falling edge; n falling edges = n samples.
    task automatic hold(input logic lvl, input int n);
        din = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_pulse(input logic b, input int w1, input int w0);
        hold(1'b1, b ? w1 : w0);
        hold(1'b0, LOWW);
    endtask

    task automatic send_byte(input logic [7:0] v, input int w1, input int w0);
        for (int i = 7; i >= 0; i--) send_pulse(v[i], w1, w0);
    endtask

    // Sends a byte and checks valid appears exactly on the 3rd edge after
    // the final falling edge, with ready=1 so it lasts one cycle.
    task automatic send_byte_lat(input logic [7:0] v, input int w1, input int w0,
                                 input logic [7:0] exp, input string nm);
        for (int i = 7; i >= 1; i--) send_pulse(v[i], w1, w0);
        hold(1'b1, v[0] ? w1 : w0);
        din = 1'b0;
        repeat (2) @(negedge clk);
        check({nm, " valid before latency"}, int'(valid), 0);
        @(negedge clk);
        check({nm, " valid at latency"}, int'(valid), 1);
        check({nm, " data"}, int'(data), int'(exp));
        hold(1'b0, LOWW - 3);
    endtask

    task automatic force_idle(input string nm);
        en = 1'b0;
        hold(1'b0, 2);
        en = 1'b1;
        hold(1'b0, 2);
        check({nm, " busy after en drop"}, int'(busy), 0);
    endtask

    typedef struct {
        logic [7:0] tx;
        int         thr;
        int         minh;
        int         w1;
        int         w0;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int s_fe, s_part, s_ovr, s_stuck, s_vrise, s_fp;

        tbl[0] = '{tx: 8'hA5, thr: 40, minh: 10, w1: 60, w0: 25, exp: 8'hA5};
        tbl[1] = '{tx: 8'h3C, thr: 40, minh: 10, w1: 60, w0: 25, exp: 8'h3C};
        tbl[2] = '{tx: 8'h00, thr: 40, minh: 10, w1: 60, w0: 25, exp: 8'h00};
        tbl[3] = '{tx: 8'hFF, thr: 40, minh: 10, w1: 60, w0: 25, exp: 8'hFF};
        tbl[4] = '{tx: 8'h5A, thr: 20, minh: 30, w1: 60, w0: 35, exp: 8'hFF}; // thresh below min: all ones
        tbl[5] = '{tx: 8'h96, thr: 40, minh: 10, w1: 40, w0: 39, exp: 8'h96}; // width == thresh decodes 1
        tbl[6] = '{tx: 8'h81, thr: 40, minh: 25, w1: 60, w0: 25, exp: 8'h81}; // width == min accepted

        reset     = 1'b0;
        en        = 1'b1;
        din       = 1'b0;
        ready     = 1'b1;
        hi_thresh = 16'd40;
        min_hi    = 16'd10;
        latch_len = 16'd2000;

        repeat (3) @(negedge clk);
        check("reset data", int'(data), 0);
        check("reset valid", int'(valid), 0);
        check("reset busy", int'(busy), 0);
        check("reset pulses", int'({frame_end, err_overrun, err_partial, err_stuck}), 0);
        reset = 1'b1;
        hold(1'b0, 3);

        // Table of single bytes, streamed back to back inside one frame.
        s_ovr = n_ovr; s_fe = n_fe;
        for (int i = 0; i < 7; i++) begin
            hi_thresh = tbl[i].thr[15:0];
            min_hi    = tbl[i].minh[15:0];
            send_byte_lat(tbl[i].tx, tbl[i].w1, tbl[i].w0, tbl[i].exp, $sformatf("vec%0d", i));
        end
        check("table busy in frame", int'(busy), 1);
        check("table no overrun", n_ovr - s_ovr, 0);
        check("table no frame end", n_fe - s_fe, 0);
        hi_thresh = 16'd40;
        min_hi    = 16'd10;
        force_idle("table");

        // Overrun: second byte arrives while first is still held.
        ready = 1'b0;
        s_ovr = n_ovr;
        send_byte(8'h3C, 60, 25);
        send_byte(8'hC3, 60, 25);
        hold(1'b0, 5);
        check("overrun data kept", int'(data), 8'h3C);
        check("overrun valid held", int'(valid), 1);
        check("overrun pulse count", n_ovr - s_ovr, 1);
        ready = 1'b1;
        @(negedge clk);
        check("overrun valid cleared", int'(valid), 0);
        force_idle("overrun");

        // Glitch inside an all-ones byte is ignored.
        s_ovr = n_ovr; s_part = n_part; s_stuck = n_stuck; s_vrise = n_vrise;
        for (int i = 0; i < 4; i++) send_pulse(1'b1, 60, 25);
        hold(1'b1, 5);
        hold(1'b0, LOWW);
        for (int i = 0; i < 4; i++) send_pulse(1'b1, 60, 25);
        hold(1'b0, 5);
        check("glitch data", int'(data), 8'hFF);
        check("glitch one byte", n_vrise - s_vrise, 1);
        check("glitch no errors", (n_ovr - s_ovr) + (n_part - s_part) + (n_stuck - s_stuck), 0);
        force_idle("glitch");

        // Enable dropped mid-byte: bits discarded without any pulse.
        s_fe = n_fe; s_part = n_part;
        send_pulse(1'b1, 60, 25);
        send_pulse(1'b0, 60, 25);
        send_pulse(1'b1, 60, 25);
        force_idle("en drop");
        check("en drop no pulses", (n_fe - s_fe) + (n_part - s_part), 0);

        // Partial frame: 5 bits then a latch-length low.
        s_fe = n_fe; s_part = n_part; s_fp = n_fe_part; s_vrise = n_vrise;
        send_pulse(1'b1, 60, 25);
        send_pulse(1'b0, 60, 25);
        send_pulse(1'b1, 60, 25);
        send_pulse(1'b1, 60, 25);
        hold(1'b1, 25);
        hold(1'b0, 2100);
        check("partial frame_end", n_fe - s_fe, 1);
        check("partial err_partial", n_part - s_part, 1);
        check("partial same cycle", n_fe_part - s_fp, 1);
        check("partial no valid", n_vrise - s_vrise, 0);
        check("partial idle", int'(busy), 0);

        // Stuck-high line, then normal reception of 0x01.
        s_stuck = n_stuck; s_vrise = n_vrise;
        hold(1'b1, 70000);
        check("stuck pulse once", n_stuck - s_stuck, 1);
        check("stuck busy", int'(busy), 1);
        hold(1'b0, LOWW);
        send_byte(8'h01, 60, 25);
        hold(1'b0, 5);
        check("after stuck data", int'(data), 8'h01);
        check("after stuck one byte", n_vrise - s_vrise, 1);

        // Reset mid-byte, then 0x0F.
        force_idle("pre reset");
        s_vrise = n_vrise;
        for (int i = 0; i < 4; i++) send_pulse(1'b1, 60, 25);
        reset = 1'b0;
        hold(1'b0, 3);
        check("mid reset data", int'(data), 0);
        check("mid reset valid", int'(valid), 0);
        check("mid reset busy", int'(busy), 0);
        reset = 1'b1;
        hold(1'b0, 3);
        send_byte(8'h0F, 60, 25);
        hold(1'b0, 5);
        check("post reset data", int'(data), 8'h0F);
        check("post reset one valid", n_vrise - s_vrise, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/rgb_rx.md
RGB_RX -- requirements
Module: rgb_rx

Interface
REQ-001 Parameter CNT_W, default 16: width of the pulse-measure counters and timing inputs.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 en  in  1  receive enable; 0 forces IDLE.
REQ-005 din  in  1  asynchronous single-wire pulse-width-coded serial input (idle low).
REQ-006 hi_thresh  in  CNT_W  high width at or above which a bit decodes as 1.
REQ-007 min_hi  in  CNT_W  high widths below this are glitches.
REQ-008 latch_len  in  CNT_W  low width that ends a frame.
REQ-009 ready  in  1  downstream accepts data when valid&ready.
REQ-010 data  out  8  received byte, MSB received first.
REQ-011 valid  out  1  data holds an unconsumed byte.
REQ-012 frame_end  out  1  one-cycle pulse on latch detection.
REQ-013 err_overrun  out  1  one-cycle pulse: byte completed while valid&!ready, new byte dropped.
REQ-014 err_partial  out  1  one-cycle pulse: frame ended with 1-7 bits pending.
REQ-015 err_stuck  out  1  one-cycle pulse: high width saturated at 2^CNT_W-1.
REQ-016 busy  out  1  FSM not in IDLE.

Function
REQ-017 din passes a 2-flop synchronizer (din_s); edges are detected by comparing din_s to its 1-cycle delayed copy.
REQ-018 Measured width W = number of clk cycles din_s held the level; a pin pulse of N clocks yields W=N; counters saturate at 2^CNT_W-1.
REQ-019 FSM states: IDLE, HIGH, LOW, STUCK.
REQ-020 IDLE -> HIGH on rising edge when en=1; otherwise stays.
REQ-021 HIGH -> LOW on falling edge: W<min_hi discards the pulse (no bit, bit count unchanged); else bit=(W>=hi_thresh) shifted into LSB of the shift register.
REQ-022 HIGH -> STUCK when high counter saturates; err_stuck pulses once, bit count cleared; STUCK -> IDLE on falling edge.
REQ-023 LOW -> HIGH on rising edge; LOW -> IDLE when low width reaches latch_len: frame_end pulses, err_partial pulses if bit count is 1-7, bit count cleared.
REQ-024 On the 8th accepted bit: if valid=0 or ready=1 in that cycle, data<=byte and valid<=1 on the next edge; else err_overrun pulses and byte is dropped; bit count wraps to 0.
REQ-025 Latency: valid rises 3 clk edges after the din pin falling edge that completes the byte.
REQ-026 valid clears the edge after valid&ready unless a new byte loads in the same cycle (then stays 1 with new data).
REQ-027 en=0 mid-byte: FSM to IDLE next edge, pending bits discarded, no error pulse; data/valid handshake unaffected.
REQ-028 latch_len=0 is treated as 1; hi_thresh<=min_hi decodes every accepted pulse as 1.

Reset
REQ-029 reset low asynchronously sets: FSM=IDLE, counters=0, bit count=0, shift=0, synchronizer=0, data=0x00, valid=0, all pulse outputs and busy=0.
REQ-030 Reset mid-byte discards the partial byte; first edge after release starts from IDLE.

Structure
REQ-031 Shared package rgb_pkg holds the FSM state enum and the default CNT_W constant.
REQ-032 One sub-module rgb_rx_meter: synchronizer, edge detect, saturating high/low width counters.

Verification
REQ-033 hi_thresh=40,min_hi=10,latch_len=2000; send 0xA5 (1=60 high,0=25 high, 50 low), ready=1 -> data=0xA5, valid 3 edges after 8th fall.
REQ-034 ready=0, send 0x3C then 0xC3 -> data stays 0x3C, one err_overrun pulse; raise ready -> valid clears.
REQ-035 5 bits then 2000 low cycles -> err_partial and frame_end pulse same cycle, no valid.
REQ-036 5-cycle high glitch inside 0xFF stream -> ignored, data=0xFF, no error.
REQ-037 din high 70000 cycles -> err_stuck once at saturation; after fall, 0x01 received correctly.
REQ-038 reset low after 4 bits of 0xF0, release, send 0x0F -> data=0x0F, valid only once.
